// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and small decode helpers.
package md_pkg;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_multicycle(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result generator for mult/multu/div/divu.
module md_calc
  import md_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_by_zero_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Products, then sign-magnitude division; the magnitude form also yields
  // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  always_comb begin
    prod_s  = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    prod_u  = {32'h0, rs_i} * {32'h0, rt_i};
    neg_a   = (op_i == MD_DIV) && rs_i[31];
    neg_b   = (op_i == MD_DIV) && rt_i[31];
    mag_a   = neg_a ? (32'h0 - rs_i) : rs_i;
    mag_b   = neg_b ? (32'h0 - rt_i) : rt_i;
    quo     = (mag_b == '0) ? '0 : (mag_a / mag_b);
    rem     = (mag_b == '0) ? '0 : (mag_a % mag_b);
    quo_fix = (neg_a ^ neg_b) ? (32'h0 - quo) : quo;
    rem_fix = neg_a ? (32'h0 - rem) : rem;

    hi_o          = '0;
    lo_o          = '0;
    div_by_zero_o = 1'b0;
    case (op_i)
      MD_MULT:  {hi_o, lo_o} = prod_s;
      MD_MULTU: {hi_o, lo_o} = prod_u;
      MD_DIV, MD_DIVU: begin
        hi_o          = rem_fix;
        lo_o          = quo_fix;
        div_by_zero_o = (rt_i == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed
// latency and reports busy to the hazard unit.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] E_reg_rs,
  input  logic [31:0] E_reg_rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  md_op_e         op;
  md_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic [31:0]    pend_hi_q, pend_hi_d;
  logic [31:0]    pend_lo_q, pend_lo_d;
  logic           pend_dbz_q, pend_dbz_d;
  logic [31:0]    calc_hi;
  logic [31:0]    calc_lo;
  logic           calc_dbz;

  assign op = md_op_e'(md_op);

  md_calc u_calc (
    .op_i          (op),
    .rs_i          (E_reg_rs),
    .rt_i          (E_reg_rt),
    .hi_o          (calc_hi),
    .lo_o          (calc_lo),
    .div_by_zero_o (calc_dbz)
  );

  // Next-state: accept ops in IDLE, count down in BUSY, commit on the last count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_dbz_d = pend_dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (md_is_multicycle(op)) begin
            pend_hi_d  = calc_hi;
            pend_lo_d  = calc_lo;
            pend_dbz_d = calc_dbz;
            cnt_d      = md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d    = BUSY;
          end else if (op == MD_MTHI) begin
            hi_d = E_reg_rs;
          end else if (op == MD_MTLO) begin
            lo_d = E_reg_rs;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (!pend_dbz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, pending and architectural registers; reset aborts any op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      pend_dbz_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_dbz_q <= pend_dbz_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: table of ops with hand-computed HI/LO and
// busy latency, plus reset-abort and start-while-busy sequences.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .E_reg_rs (rs),
    .E_reg_rt (rt),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Protocol monitor: start presented while an operation is in flight.
  always @(posedge clk) if (reset && start && busy) viol++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one op for exactly one rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op;
    rs    = a;
    rt    = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = 3'd0;
  endtask

  // Count busy cycles at negedges; while busy, HI/LO must still show old values.
  task automatic measure(input string tag, input logic [31:0] ph, input logic [31:0] pl,
                         output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      if (n == 0) begin
        check({tag, "_hold_hi"}, 64'(hi), 64'(ph));
        check({tag, "_hold_lo"}, 64'(lo), 64'(pl));
      end
      n++;
      @(negedge clk);
    end
    if (n >= 100) check({tag, "_timeout"}, 64'(n), 64'(0));
  endtask

  initial begin
    logic [31:0] ph;
    logic [31:0] pl;
    int n;
    int bad;

    vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
    vecs[4]  = '{3'd5, 32'h12345678, 32'h0,        32'h12345678, 32'h00000003, 0};
    vecs[5]  = '{3'd6, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
    vecs[6]  = '{3'd5, 32'h00000001, 32'h0,        32'h00000001, 32'h9ABCDEF0, 0};
    vecs[7]  = '{3'd6, 32'h00000002, 32'h0,        32'h00000001, 32'h00000002, 0};
    vecs[8]  = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000002, 10};
    vecs[9]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[10] = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[11] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[12] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[13] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[14] = '{3'd4, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[15] = '{3'd4, 32'h00000005, 32'h00000000, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[16] = '{3'd7, 32'hDEADBEEF, 32'h00000001, 32'h0000000F, 32'h0FFFFFFF, 0};
    vecs[17] = '{3'd0, 32'hCAFEF00D, 32'h00000003, 32'h0000000F, 32'h0FFFFFFF, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    reset = 1'b1;

    // Table: each op is issued in the cycle the previous one's busy falls.
    ph = '0;
    pl = '0;
    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      measure($sformatf("v%0d", i), ph, pl, n);
      check($sformatf("v%0d_lat", i), 64'(n), 64'(vecs[i].lat));
      check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
      ph = vecs[i].exp_hi;
      pl = vecs[i].exp_lo;
    end
    check("no_viol_table", 64'(viol), 64'(0));

    // start held for two extra edges while busy: ignored, first op completes.
    md_op = 3'd1;
    rs    = 32'd3;
    rt    = 32'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    rs = 32'd5;
    rt = 32'd5;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    md_op = 3'd0;
    check("held_viol", 64'(viol), 64'(2));
    measure("held", ph, pl, n);
    check("held_lat_rem", 64'(n), 64'(3));
    check("held_hi", 64'(hi), 64'(0));
    check("held_lo", 64'(lo), 64'(12));

    // Reset three cycles into a div aborts it asynchronously, no later commit.
    issue(3'd1, 32'h00010000, 32'h00010000);
    measure("pre", 32'h0, 32'd12, n);
    check("pre_hi", 64'(hi), 64'(1));
    check("pre_lo", 64'(lo), 64'(0));
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy || hi != 32'h0 || lo != 32'h0) bad++;
    end
    check("abort_no_commit", 64'(bad), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
